// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: step operations and control FSM states.
package usr_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/usr_step.sv
// Combinational single-bit step of the shift register: rotate or shift one position in either direction.
import usr_pkg::*;

module usr_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_SHR:  q_next = {sin, q[WIDTH-1:1]};
      OP_SHL:  q_next = {q[WIDTH-2:0], sin};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load and multi-step rotate/shift operations;
// the first step happens on the edge that samples start, the rest are sequenced by a small FSM.
import usr_pkg::*;

module universal_shift_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {1'b1, {(WIDTH-1){1'b0}}},
  localparam int unsigned     AMT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           state_next;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] remaining_next;
  op_e              op_lat;
  op_e              op_lat_next;
  op_e              step_op;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] q_next;
  logic             done_next;
  logic             multi_step;

  assign multi_step = (amount >= AMT_W'(2));

  usr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q      (q),
    .op     (step_op),
    .sin    (sin),
    .q_next (step_q)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; load always returns to IDLE
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start && multi_step) state_next = ST_RUN;
        ST_RUN:  if (remaining == AMT_W'(1)) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath next values; in RUN the latched op is used and start/op/amount are ignored
  always_comb begin
    q_next         = q;
    remaining_next = remaining;
    op_lat_next    = op_lat;
    done_next      = 1'b0;
    step_op        = op_e'(op);
    if (load) begin
      q_next         = d;
      remaining_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_lat_next    = op_e'(op);
            remaining_next = multi_step ? (amount - AMT_W'(1)) : '0;
            done_next      = !multi_step;
            if (amount != '0) q_next = step_q;
          end
        end
        ST_RUN: begin
          step_op        = op_lat;
          q_next         = step_q;
          remaining_next = remaining - AMT_W'(1);
          done_next      = (remaining == AMT_W'(1));
        end
        default: begin
          remaining_next = '0;
        end
      endcase
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      q         <= RESET_VALUE;
      remaining <= '0;
      op_lat    <= OP_ROR;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      q         <= q_next;
      remaining <= remaining_next;
      op_lat    <= op_lat_next;
      done      <= done_next;
      busy      <= (state_next == ST_RUN);
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomized self-checking bench: closed-form rotate/shift model feeds a scoreboard checked on done.
module tb_universal_shift_register;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  d;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] amount;
  logic          sin;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;

  always #5 clock = ~clock;

  universal_shift_register #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .d      (d),
    .start  (start),
    .op     (op),
    .amount (amount),
    .sin    (sin),
    .q      (q),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [W-1:0] exp_q;
    int           exp_busy;
  } exp_t;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] mq;
  bit           mon_en      = 1'b0;
  int           bcnt        = 0;
  logic         prev_done   = 1'b0;

  // Result of applying n steps of an operation in one go
  function automatic logic [W-1:0] model(logic [W-1:0] v, logic [1:0] o, int n, logic s);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   fill;
    logic [W-1:0]   ones;
    int             r;
    dbl  = {v, v};
    fill = {W{s}};
    ones = {W{1'b1}};
    r    = n % W;
    case (o)
      2'b00: begin dbl = dbl >> r; return dbl[W-1:0]; end
      2'b01: begin dbl = dbl << r; return dbl[2*W-1:W]; end
      2'b10: if (n >= W) return fill; else return (v >> n) | (fill & ~(ones >> n));
      default: if (n >= W) return fill; else return (v << n) | (fill & ~(ones << n));
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'(0));
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("final_q", 32'(q), 32'(e.exp_q));
          check("busy_cycles", 32'(bcnt), 32'(e.exp_busy));
          check("busy_at_done", 32'(busy), 32'(0));
        end
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
    prev_done = done;
  end

  task automatic do_load(logic [W-1:0] v);
    load = 1'b1;
    d    = v;
    tick();
    load = 1'b0;
    d    = W'($urandom);
    mq   = v;
    @(negedge clock);
    check("load_q", 32'(q), 32'(v));
    tick();
  endtask

  task automatic run_op(logic [1:0] o, int amt, logic s);
    logic [W-1:0] q0;
    int           n;
    exp_t         e;
    q0         = mq;
    n          = (amt == 0) ? 1 : amt;
    e.exp_q    = model(q0, o, amt, s);
    e.exp_busy = (amt >= 2) ? amt - 1 : 0;
    sb.push_back(e);
    start  = 1'b1;
    op     = o;
    amount = AW'(amt);
    sin    = s;
    tick();
    start  = 1'b0;
    op     = 2'($urandom);
    amount = AW'($urandom);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      check("step_q", 32'(q), 32'(model(q0, o, (amt == 0) ? 0 : k, s)));
      if (k < n) begin
        check("busy_mid", 32'(busy), 32'(1));
        tick();
        start  = (k + 1 < n) ? 1'($urandom) : 1'b0;
        op     = 2'($urandom);
        amount = AW'($urandom);
      end
    end
    start = 1'b0;
    mq    = e.exp_q;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    amount = '0;
    sin    = 1'b0;
    d      = '0;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("reset_q", 32'(q), 32'h80);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    mq = 8'h80;
    tick();

    run_op(2'b00, 8, 1'b0);
    do_load(8'hA5);
    run_op(2'b01, 3, 1'b0);
    do_load(8'h00);
    run_op(2'b10, 4, 1'b1);
    do_load(8'hFF);
    run_op(2'b11, 9, 1'b0);

    // Load on the second busy cycle aborts without done
    do_load(8'h80);
    start  = 1'b1;
    op     = 2'b00;
    amount = AW'(6);
    tick();
    start  = 1'b0;
    tick();
    load   = 1'b1;
    d      = 8'h3C;
    tick();
    load   = 1'b0;
    @(negedge clock);
    check("abort_q", 32'(q), 32'h3C);
    check("abort_busy", 32'(busy), 32'(0));
    mq = 8'h3C;
    repeat (10) tick();

    run_op(2'b01, 0, 1'b1);
    run_op(2'b10, 1, 1'b1);
    run_op(2'b00, 15, 1'b0);

    // Reset mid-operation aborts without done
    start  = 1'b1;
    op     = 2'b11;
    amount = AW'(12);
    sin    = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    @(negedge clock);
    check("midrun_reset_q", 32'(q), 32'h80);
    check("midrun_reset_busy", 32'(busy), 32'(0));
    check("midrun_reset_done", 32'(done), 32'(0));
    mq = 8'h80;
    repeat (5) tick();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0) do_load(W'($urandom));
      run_op(2'($urandom), int'($urandom_range(15, 0)), 1'($urandom));
    end

    repeat (4) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (>= 2).
REQ-002 SHALL have parameter RESET_VALUE, default MSB-only set (8'h80 at WIDTH=8), value loaded by reset.
REQ-003 SHALL have derived localparam AMT_W = clog2(WIDTH+1), step-count width.
REQ-004 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port load  in  1  parallel load of d.
REQ-007 SHALL have port d  in  WIDTH  parallel load data.
REQ-008 SHALL have port start  in  1  request a multi-step operation.
REQ-009 SHALL have port op  in  2  00 rotate right, 01 rotate left, 10 shift right (sin->MSB), 11 shift left (sin->LSB).
REQ-010 SHALL have port amount  in  AMT_W  number of single-bit steps, 0..2^AMT_W-1.
REQ-011 SHALL have port sin  in  1  serial input for shift ops.
REQ-012 SHALL have port q  out  WIDTH  register contents.
REQ-013 SHALL have port busy  out  1  multi-step operation in progress.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; busy = (state == RUN).
REQ-016 SHALL perform one step per step-edge: rotate right q <= {q[0], q[W-1:1]}; rotate left q <= {q[W-2:0], q[W-1]}; shift right q <= {sin, q[W-1:1]}; shift left q <= {q[W-2:0], sin}.
REQ-017 In IDLE with start=1, load=0, amount=N>=2: SHALL perform step 1 at that edge, latch op, set remaining = N-1, enter RUN.
REQ-018 In IDLE with start=1, load=0, amount=1: SHALL perform one step, stay IDLE, assert done next cycle.
REQ-019 In IDLE with start=1, load=0, amount=0: SHALL leave q unchanged, stay IDLE, assert done next cycle.
REQ-020 In RUN: SHALL perform one step per edge using latched op and live sin; decrement remaining; on the step where remaining==1, return to IDLE and assert done for exactly the following cycle.
REQ-021 Total latency: steps at edges E0..E(N-1) after start sampled at E0; busy high N-1 cycles; done high one cycle after E(N-1).
REQ-022 Amounts > WIDTH SHALL be honoured step-by-step (rotations wrap modulo WIDTH; shifts keep feeding sin).
REQ-023 start while busy SHALL be ignored; op/amount changes while busy SHALL have no effect.
REQ-024 load SHALL take priority over start: q <= d, state IDLE, remaining cleared, no done pulse, in any state.
REQ-025 load during RUN SHALL abort the operation (no done for the aborted op).
REQ-026 done SHALL be registered and never high for more than one consecutive cycle per operation.

Reset
REQ-027 On reset=1 at a clock edge: q <= RESET_VALUE, state IDLE, remaining 0, busy 0, done 0.
REQ-028 Reset SHALL override load and start and abort any operation mid-RUN without a done pulse.
REQ-029 Outputs SHALL be undefined only before the first reset edge; no asynchronous paths.

Structure
REQ-030 Shared package usr_pkg SHALL hold op encodings (OP_ROR, OP_ROL, OP_SHR, OP_SHL) and FSM state encodings.
REQ-031 Single-step next-value logic SHALL be a combinational sub-module usr_step (inputs q, op, sin; output next q), parametrised by WIDTH.
REQ-032 FSM, step counter, and q register SHALL reside in universal_shift_register.

Verification (WIDTH=8, default RESET_VALUE)
REQ-033 Reset 1 cycle -> q=8'h80, busy=0, done=0.
REQ-034 From 8'h80, start op=00 amount=8 -> q 40,20,10,08,04,02,01,80 on successive edges; busy high 7 cycles; done one cycle after final step.
REQ-035 load d=8'hA5, then start op=01 amount=3 -> q 4B, 96, 2D; done pulse once.
REQ-036 load 8'h00, start op=10 amount=4 sin=1 -> q=8'hF0; load 8'hFF, start op=11 amount=9 sin=0 -> q=8'h00.
REQ-037 From 8'h80, start op=00 amount=6, assert load d=8'h3C on second busy cycle -> q=8'h3C next edge, busy=0, no done ever for that op.
REQ-038 start amount=0 -> q unchanged, done one cycle, busy stays 0; start pulsed during busy -> ignored, single done.
